rob_commit: RTL and testbench

- Reorder buffer sitting directly downstream of the rename/decode stage.
- Allocates ROB IDs for up to WIDTH renamed micro-ops per cycle and records each op's displaced (old) physical aliases and destination arch regs.
- Marks entries done on execution completion.
- Retires done entries in program order, up to COMMIT_W per cycle. Retired old aliases feed back to the renamer's free-pool input (30 bits = 3 ops x 2 x 5-bit aliases).

---
 rtl/rob_commit.sv | 126 ++++++++++++
 tb/tb_rob_commit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Reorder buffer: allocates IDs for renamed micro-ops, tracks completion, and retires
// done entries in program order, returning displaced physical aliases to the free pool.
`ifndef PR_ADDR_W
`define PR_ADDR_W 5
`endif

module rob_commit #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned COMMIT_W  = 3,
    parameter int unsigned NCMPLT    = 6,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned PR_ADDR_W = `PR_ADDR_W,
    localparam int unsigned IDW      = $clog2(DEPTH),
    localparam int unsigned CW       = IDW + 1,
    localparam int unsigned AW       = 2 * PR_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [IDW*WIDTH-1:0]   alloc_ids,
    input  logic [WIDTH-1:0]       dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [AW*WIDTH-1:0]    dispatch_old_aliases,
    input  logic [8*WIDTH-1:0]     dispatch_arch_regs,
    input  logic [NCMPLT-1:0]      complete_valid,
    input  logic [IDW*NCMPLT-1:0]  complete_rob_id,
    output logic [COMMIT_W-1:0]    commit_valid,
    output logic [AW*COMMIT_W-1:0] commit_old_aliases,
    output logic [8*COMMIT_W-1:0]  commit_arch_regs,
    output logic                   rob_empty,
    output logic [CW-1:0]          rob_count
);

    logic [IDW-1:0] head_q, head_d;
    logic [IDW-1:0] tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [AW-1:0]  alias_q [DEPTH];
    logic [AW-1:0]  alias_d [DEPTH];
    logic [7:0]     arch_q  [DEPTH];
    logic [7:0]     arch_d  [DEPTH];

    logic           fire;
    logic           run_done;
    logic [CW-1:0]  disp_cnt;
    logic [CW-1:0]  commit_cnt;

    always_comb begin
        dispatch_ready = (count_q <= CW'(DEPTH - WIDTH));
        rob_empty      = (count_q == '0);
        rob_count      = count_q;
        for (int i = 0; i < WIDTH; i++) begin
            alloc_ids[i*IDW +: IDW] = tail_q + IDW'(i);
        end
    end

    // Retire the longest run of done entries starting at head, capped at COMMIT_W.
    always_comb begin
        commit_valid       = '0;
        commit_old_aliases = '0;
        commit_arch_regs   = '0;
        commit_cnt         = '0;
        run_done           = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            run_done = run_done && (CW'(i) < count_q) && done_q[head_q + IDW'(i)];
            if (run_done) begin
                commit_valid[i]              = 1'b1;
                commit_old_aliases[i*AW +: AW] = alias_q[head_q + IDW'(i)];
                commit_arch_regs[i*8 +: 8]   = arch_q[head_q + IDW'(i)];
                commit_cnt                   = commit_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        fire     = dispatch_ready && (|dispatch_valid);
        disp_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            disp_cnt = disp_cnt + CW'(dispatch_valid[i]);
        end

        head_d  = head_q + commit_cnt[IDW-1:0];
        tail_d  = fire ? tail_q + disp_cnt[IDW-1:0] : tail_q;
        count_d = fire ? count_q + disp_cnt - commit_cnt : count_q - commit_cnt;

        done_d  = done_q;
        alias_d = alias_q;
        arch_d  = arch_q;

        // Offset from head below count means the ID is currently occupied.
        for (int p = 0; p < NCMPLT; p++) begin
            if (complete_valid[p] &&
                (CW'(IDW'(complete_rob_id[p*IDW +: IDW] - head_q)) < count_q)) begin
                done_d[complete_rob_id[p*IDW +: IDW]] = 1'b1;
            end
        end

        // Dispatch is applied last so it overrides a colliding completion.
        for (int i = 0; i < WIDTH; i++) begin
            if (fire && dispatch_valid[i]) begin
                done_d[tail_q + IDW'(i)]  = 1'b0;
                alias_d[tail_q + IDW'(i)] = dispatch_old_aliases[i*AW +: AW];
                arch_d[tail_q + IDW'(i)]  = dispatch_arch_regs[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        alias_q <= alias_d;
        arch_q  <= arch_d;
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: vector table for the basic flow, hand sequences for
// fill/backpressure, async reset, and pointer wrap-around.
module tb_rob_commit;

    logic        clk;
    logic        rst;
    logic [19:0] alloc_ids;
    logic [3:0]  dispatch_valid;
    logic        dispatch_ready;
    logic [39:0] dispatch_old_aliases;
    logic [31:0] dispatch_arch_regs;
    logic [5:0]  complete_valid;
    logic [29:0] complete_rob_id;
    logic [2:0]  commit_valid;
    logic [29:0] commit_old_aliases;
    logic [23:0] commit_arch_regs;
    logic        rob_empty;
    logic [5:0]  rob_count;

    int nvec = 0;
    int nmis = 0;
    int seq  = 0;
    logic [17:0] sb[$];

    rob_commit dut (
        .clk                  (clk),
        .rst                  (rst),
        .alloc_ids            (alloc_ids),
        .dispatch_valid       (dispatch_valid),
        .dispatch_ready       (dispatch_ready),
        .dispatch_old_aliases (dispatch_old_aliases),
        .dispatch_arch_regs   (dispatch_arch_regs),
        .complete_valid       (complete_valid),
        .complete_rob_id      (complete_rob_id),
        .commit_valid         (commit_valid),
        .commit_old_aliases   (commit_old_aliases),
        .commit_arch_regs     (commit_arch_regs),
        .rob_empty            (rob_empty),
        .rob_count            (rob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            assert ((dispatch_valid & (dispatch_valid + 4'd1)) == 4'd0)
                else $error("dispatch_valid not thermometer: %b", dispatch_valid);
            assert (rob_count <= 6'd32) else $error("rob_count above depth: %0d", rob_count);
        end
    end

    typedef struct {
        string       nm;
        logic [3:0]  dv;
        logic [5:0]  cv;
        logic [29:0] cid;
        logic [2:0]  ecv;
        int          cnt;
        int          tail;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [9:0] pay_alias(input int s);
        return 10'(s * 37 + 5);
    endfunction

    function automatic logic [7:0] pay_arch(input int s);
        return 8'(s * 11 + 3);
    endfunction

    function automatic logic [29:0] ids(input int a, input int b, input int c,
                                        input int d, input int e, input int f);
        return {5'(f), 5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string nm, input logic [2:0] ecv, input int ecnt,
                                 input int etail);
        logic [19:0] ealloc;
        logic [17:0] e;
        for (int i = 0; i < 4; i++) ealloc[i*5 +: 5] = 5'(etail + i);
        chk({nm, ":count"}, 32'(rob_count), 32'(ecnt));
        chk({nm, ":empty"}, 32'(rob_empty), 32'(ecnt == 0));
        chk({nm, ":ready"}, 32'(dispatch_ready), 32'(ecnt <= 28));
        chk({nm, ":alloc"}, 32'(alloc_ids), 32'(ealloc));
        chk({nm, ":cvalid"}, 32'(commit_valid), 32'(ecv));
        for (int i = 0; i < 3; i++) begin
            e = (ecv[i] && i < sb.size()) ? sb[i] : 18'd0;
            chk($sformatf("%s:alias%0d", nm, i), 32'(commit_old_aliases[i*10 +: 10]),
                32'(e[9:0]));
            chk($sformatf("%s:arch%0d", nm, i), 32'(commit_arch_regs[i*8 +: 8]),
                32'(e[17:10]));
        end
    endtask

    // One clock: drive inputs, check pre-edge outputs, then update the scoreboard.
    task automatic cycle(input string nm, input logic [3:0] dv, input logic [5:0] cv,
                         input logic [29:0] cid, input logic [2:0] ecv, input int ecnt,
                         input int etail);
        dispatch_valid = dv;
        for (int i = 0; i < 4; i++) begin
            dispatch_old_aliases[i*10 +: 10] = dv[i] ? pay_alias(seq + i) : 10'd0;
            dispatch_arch_regs[i*8 +: 8]     = dv[i] ? pay_arch(seq + i) : 8'd0;
        end
        complete_valid  = cv;
        complete_rob_id = cid;
        @(negedge clk);
        check_outputs(nm, ecv, ecnt, etail);
        @(posedge clk);
        #1;
        if (ecnt <= 28) begin
            for (int i = 0; i < 4; i++) begin
                if (dv[i]) begin
                    sb.push_back({pay_arch(seq), pay_alias(seq)});
                    seq++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (ecv[i] && sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        logic [19:0] rst_alloc;
        rst_alloc = {5'd3, 5'd2, 5'd1, 5'd0};

        tbl[0]  = '{"idle",      4'h0, 6'h00, 30'd0,              3'b000, 0, 0};
        tbl[1]  = '{"disp4",     4'hF, 6'h00, 30'd0,              3'b000, 0, 0};
        tbl[2]  = '{"cmp1200",   4'h0, 6'h0F, ids(1, 2, 0, 0, 0, 0), 3'b000, 4, 4};
        tbl[3]  = '{"commit012", 4'h0, 6'h00, 30'd0,              3'b111, 4, 4};
        tbl[4]  = '{"disp4b",    4'hF, 6'h00, 30'd0,              3'b000, 1, 4};
        tbl[5]  = '{"cmp56",     4'h0, 6'h03, ids(5, 6, 0, 0, 0, 0), 3'b000, 5, 8};
        tbl[6]  = '{"cmp3",      4'h0, 6'h01, ids(3, 0, 0, 0, 0, 0), 3'b000, 5, 8};
        tbl[7]  = '{"commit3",   4'h0, 6'h00, 30'd0,              3'b001, 5, 8};
        tbl[8]  = '{"cmp4",      4'h0, 6'h01, ids(4, 0, 0, 0, 0, 0), 3'b000, 4, 8};
        tbl[9]  = '{"commit456", 4'h0, 6'h00, 30'd0,              3'b111, 4, 8};
        tbl[10] = '{"cmp_oor",   4'h0, 6'h01, ids(20, 0, 0, 0, 0, 0), 3'b000, 1, 8};

        rst = 1'b1;
        dispatch_valid = '0;
        dispatch_old_aliases = '0;
        dispatch_arch_regs = '0;
        complete_valid = '0;
        complete_rob_id = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 11; v++) begin
            cycle(tbl[v].nm, tbl[v].dv, tbl[v].cv, tbl[v].cid, tbl[v].ecv, tbl[v].cnt,
                  tbl[v].tail);
        end

        // Fill to 29 entries; entry 7 at head is still pending.
        for (int j = 0; j < 7; j++) begin
            cycle($sformatf("fill%0d", j), 4'hF, 6'h00, 30'd0, 3'b000, 1 + 4 * j,
                  (8 + 4 * j) % 32);
        end
        cycle("full_block", 4'hF, 6'h00, 30'd0, 3'b000, 29, 4);
        cycle("cmp7_full", 4'hF, 6'h01, ids(7, 0, 0, 0, 0, 0), 3'b000, 29, 4);
        cycle("commit7_full", 4'hF, 6'h00, 30'd0, 3'b001, 29, 4);
        cycle("ready_again", 4'h0, 6'h00, 30'd0, 3'b000, 28, 4);
        cycle("cmp8", 4'h0, 6'h01, ids(8, 0, 0, 0, 0, 0), 3'b000, 28, 4);

        // Asynchronous reset in the middle of a cycle with a commit in flight.
        dispatch_valid = '0;
        complete_valid = '0;
        #2;
        chk("pre_rst:cvalid", 32'(commit_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst:cvalid", 32'(commit_valid), 32'd0);
        chk("async_rst:alias", 32'(commit_old_aliases), 32'd0);
        chk("async_rst:arch", 32'(commit_arch_regs), 32'd0);
        chk("async_rst:count", 32'(rob_count), 32'd0);
        chk("async_rst:empty", 32'(rob_empty), 32'd1);
        chk("async_rst:ready", 32'(dispatch_ready), 32'd1);
        chk("async_rst:alloc", 32'(alloc_ids), 32'(rst_alloc));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();

        cycle("cmp5_after_rst", 4'h0, 6'h01, ids(5, 0, 0, 0, 0, 0), 3'b000, 0, 0);
        cycle("empty_after_rst", 4'h0, 6'h00, 30'd0, 3'b000, 0, 0);

        // Walk head and tail to 30 with one-op pipelined dispatch/complete/commit.
        for (int c = 0; c < 30; c++) begin
            cycle($sformatf("walk%0d", c), 4'h1, (c >= 1) ? 6'h01 : 6'h00,
                  ids(c - 1, 0, 0, 0, 0, 0), (c >= 2) ? 3'b001 : 3'b000,
                  (c == 0) ? 0 : ((c == 1) ? 1 : 2), c);
        end
        cycle("walk30", 4'h0, 6'h01, ids(29, 0, 0, 0, 0, 0), 3'b001, 2, 30);
        cycle("walk31", 4'h0, 6'h00, 30'd0, 3'b001, 1, 30);

        cycle("wrap_disp", 4'hF, 6'h00, 30'd0, 3'b000, 0, 30);
        cycle("wrap_cmp", 4'h0, 6'h0F, ids(30, 31, 0, 1, 0, 0), 3'b000, 4, 2);
        cycle("wrap_commit3", 4'h0, 6'h00, 30'd0, 3'b111, 4, 2);
        cycle("wrap_commit1", 4'h0, 6'h00, 30'd0, 3'b001, 1, 2);
        cycle("head2_disp", 4'h1, 6'h00, 30'd0, 3'b000, 0, 2);
        cycle("head2_cmp", 4'h0, 6'h01, ids(2, 0, 0, 0, 0, 0), 3'b000, 1, 3);
        cycle("head2_commit", 4'h0, 6'h00, 30'd0, 3'b001, 1, 3);
        cycle("final_empty", 4'h0, 6'h00, 30'd0, 3'b000, 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
